// File: rtl/inst_fetch_if.sv
// Single-line instruction buffer between the core fetch port and a req/ack memory.
// Hits are served combinationally; a miss stalls the core while the whole line is burst-filled.
module inst_fetch_if #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [DATA_W-1:0] rom_data_o,
  output logic              stallreq_o,
  input  logic              invalidate_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int TAG_W = ADDR_W - OFF_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic              pend_inv_q, pend_inv_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] line_q [LINE_WORDS];

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [IDX_W-1:0]      fill_idx_inc;
  logic                  hit, miss, fill_last, fill_we;
  logic [LINE_WORDS-1:0] word_we;
  logic                  addr_lsb_unused;

  assign req_tag         = rom_addr_i[ADDR_W-1:OFF_W];
  assign req_idx         = rom_addr_i[OFF_W-1:2];
  assign addr_lsb_unused = ^rom_addr_i[1:0];

  assign hit          = rom_ce_i & valid_q & (tag_q == req_tag) & (state_q == IDLE);
  assign miss         = rom_ce_i & ~hit;
  assign fill_idx_inc = fill_idx_q + IDX_W'(1);
  assign fill_last    = (fill_idx_q == IDX_W'(LINE_WORDS - 1));
  assign fill_we      = ~rst & (state_q == FILL) & mem_ack_i;

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

  // Reset masks the core-facing outputs even if a fill was in flight.
  always_comb begin
    rom_data_o = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      if (hit) rom_data_o = line_q[req_idx];
      stallreq_o = miss | (state_q == FILL);
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    pend_inv_d = pend_inv_q;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    tag_d      = tag_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (invalidate_i) valid_d = 1'b0;
        if (miss) begin
          state_d    = FILL;
          fill_tag_d = req_tag;
          fill_idx_d = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {req_tag, {OFF_W{1'b0}}};
        end
      end
      FILL: begin
        if (invalidate_i) pend_inv_d = 1'b1;
        if (mem_ack_i) begin
          fill_idx_d = fill_idx_inc;
          if (fill_last) begin
            // A late invalidate on the final ack still leaves the new line invalid.
            state_d    = IDLE;
            tag_d      = fill_tag_q;
            valid_d    = ~(pend_inv_q | invalidate_i);
            pend_inv_d = 1'b0;
            mem_req_d  = 1'b0;
          end else begin
            mem_addr_d = {fill_tag_q, fill_idx_inc, 2'b00};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      pend_inv_q <= 1'b0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      tag_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      pend_inv_q <= pend_inv_d;
      fill_idx_q <= fill_idx_d;
      fill_tag_q <= fill_tag_d;
      tag_q      <= tag_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word_we
      assign word_we[gi] = fill_we & (fill_idx_q == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (word_we[i]) line_q[i] <= mem_data_i;
    end
  end

endmodule
